// File: rtl/memory_bank_2p.sv
// memory_bank_2p
//
// Dual-port scratchpad memory bank. Each port carries a valid/ready request
// with a per-column write mask; an all-zero mask is a read. Every accepted
// request, read or write, returns the word as it was before that cycle's
// writes. After every reset the bank zero-fills itself, one word per cycle,
// before it raises init_done and starts accepting requests.
//
// Same-address requests where at least one side writes are serialised by a
// round-robin pointer that starts at port A after reset and flips on each
// such conflict.
//
// Optional feature (macro MEMORY_BANK_2P_OUT_REG_EN):
//   defined   -> read_data/resp_valid pass through one extra register stage,
//                so the response arrives two cycles after acceptance.
//   undefined -> response arrives one cycle after acceptance.
//
// Ports
//   clock           in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   init_done       out  zero-fill complete, bank accepting requests
//   a_req_valid     in   port A request valid
//   a_req_ready     out  port A request accepted when valid & ready
//   a_address       in   port A word address
//   a_write_enable  in   port A column write mask (all zero = read)
//   a_write_data    in   port A write data
//   a_resp_valid    out  port A one-cycle response strobe
//   a_read_data     out  port A pre-write word contents (held between strobes)
//   b_*                  port B, identical to port A

module memory_bank_2p #(
   parameter int SIZE       = 1024,
   parameter int ADDR_WIDTH = $clog2(SIZE),
   parameter int COL_WIDTH  = 8,
   parameter int NB_COL     = 4
) (
   input  logic                            clock,
   input  logic                            reset_n,
   output logic                            init_done,
   input  logic                            a_req_valid,
   output logic                            a_req_ready,
   input  logic [ADDR_WIDTH-1:0]           a_address,
   input  logic [NB_COL-1:0]               a_write_enable,
   input  logic [NB_COL*COL_WIDTH-1:0]     a_write_data,
   output logic                            a_resp_valid,
   output logic [NB_COL*COL_WIDTH-1:0]     a_read_data,
   input  logic                            b_req_valid,
   output logic                            b_req_ready,
   input  logic [ADDR_WIDTH-1:0]           b_address,
   input  logic [NB_COL-1:0]               b_write_enable,
   input  logic [NB_COL*COL_WIDTH-1:0]     b_write_data,
   output logic                            b_resp_valid,
   output logic [NB_COL*COL_WIDTH-1:0]     b_read_data
);

   localparam int W = NB_COL * COL_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   // 0: port A wins the next conflict, 1: port B wins it
   logic                  rr_q, rr_d;
   logic                  a_resp_valid_q, a_resp_valid_d;
   logic                  b_resp_valid_q, b_resp_valid_d;
   logic [W-1:0]          a_read_data_q, a_read_data_d;
   logic [W-1:0]          b_read_data_q, b_read_data_d;

   // Storage has no reset; the INIT sweep clears it instead.
   logic [W-1:0]          mem [SIZE];

   logic run;
   logic conflict;
   logic a_accept, b_accept;
   logic a_in_range, b_in_range;

   // Addresses beyond SIZE only exist when SIZE is not a power of two.
   generate
      if (SIZE < (1 << ADDR_WIDTH)) begin : g_range_check
         localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH+1)'(SIZE);
         assign a_in_range = ({1'b0, a_address} < SIZE_EXT);
         assign b_in_range = ({1'b0, b_address} < SIZE_EXT);
      end else begin : g_full_range
         assign a_in_range = 1'b1;
         assign b_in_range = 1'b1;
      end
   endgenerate

   // Arbitration: only a same-address pair involving a write is a conflict;
   // then the round-robin pointer picks exactly one port.
   always_comb begin
      run         = (state_q == ST_RUN);
      conflict    = a_req_valid & b_req_valid & (a_address == b_address)
                    & ((|a_write_enable) | (|b_write_enable));
      a_req_ready = run & (~conflict | ~rr_q);
      b_req_ready = run & (~conflict | rr_q);
      a_accept    = a_req_valid & a_req_ready;
      b_accept    = b_req_valid & b_req_ready;
   end

   // Next state: zero-fill sweep, pointer update and read-first capture.
   always_comb begin
      state_d        = state_q;
      init_cnt_d     = init_cnt_q;
      rr_d           = rr_q;
      a_resp_valid_d = a_accept;
      b_resp_valid_d = b_accept;
      a_read_data_d  = a_read_data_q;
      b_read_data_d  = b_read_data_q;

      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + 1'b1;
         if (init_cnt_q == LAST_ADDR) begin
            state_d = ST_RUN;
         end
      end

      if (run && conflict) begin
         rr_d = ~rr_q;
      end

      if (a_accept) begin
         a_read_data_d = a_in_range ? mem[a_address] : '0;
      end
      if (b_accept) begin
         b_read_data_d = b_in_range ? mem[b_address] : '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_INIT;
         init_cnt_q     <= '0;
         rr_q           <= 1'b0;
         a_resp_valid_q <= 1'b0;
         b_resp_valid_q <= 1'b0;
         a_read_data_q  <= '0;
         b_read_data_q  <= '0;
      end else begin
         state_q        <= state_d;
         init_cnt_q     <= init_cnt_d;
         rr_q           <= rr_d;
         a_resp_valid_q <= a_resp_valid_d;
         b_resp_valid_q <= b_resp_valid_d;
         a_read_data_q  <= a_read_data_d;
         b_read_data_q  <= b_read_data_d;
      end
   end

   // Storage writes. The conflict rule guarantees the two ports never write
   // the same word in one cycle.
   always_ff @(posedge clock) begin
      if (state_q == ST_INIT) begin
         mem[init_cnt_q] <= '0;
      end else begin
         for (int c = 0; c < NB_COL; c++) begin
            if (a_accept && a_in_range && a_write_enable[c]) begin
               mem[a_address][c*COL_WIDTH +: COL_WIDTH] <= a_write_data[c*COL_WIDTH +: COL_WIDTH];
            end
            if (b_accept && b_in_range && b_write_enable[c]) begin
               mem[b_address][c*COL_WIDTH +: COL_WIDTH] <= b_write_data[c*COL_WIDTH +: COL_WIDTH];
            end
         end
      end
   end

   assign init_done = (state_q == ST_RUN);

`ifdef MEMORY_BANK_2P_OUT_REG_EN
   logic         a_resp_valid_o_q, a_resp_valid_o_d;
   logic         b_resp_valid_o_q, b_resp_valid_o_d;
   logic [W-1:0] a_read_data_o_q, a_read_data_o_d;
   logic [W-1:0] b_read_data_o_q, b_read_data_o_d;

   // The second stage simply follows the first; the first already holds
   // read_data between responses, so the hold behaviour carries through.
   always_comb begin
      a_resp_valid_o_d = a_resp_valid_q;
      b_resp_valid_o_d = b_resp_valid_q;
      a_read_data_o_d  = a_read_data_q;
      b_read_data_o_d  = b_read_data_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_resp_valid_o_q <= 1'b0;
         b_resp_valid_o_q <= 1'b0;
         a_read_data_o_q  <= '0;
         b_read_data_o_q  <= '0;
      end else begin
         a_resp_valid_o_q <= a_resp_valid_o_d;
         b_resp_valid_o_q <= b_resp_valid_o_d;
         a_read_data_o_q  <= a_read_data_o_d;
         b_read_data_o_q  <= b_read_data_o_d;
      end
   end

   assign a_resp_valid = a_resp_valid_o_q;
   assign b_resp_valid = b_resp_valid_o_q;
   assign a_read_data  = a_read_data_o_q;
   assign b_read_data  = b_read_data_o_q;
`else
   assign a_resp_valid = a_resp_valid_q;
   assign b_resp_valid = b_resp_valid_q;
   assign a_read_data  = a_read_data_q;
   assign b_read_data  = b_read_data_q;
`endif

endmodule
